// File: rtl/key_event.sv
// Turns a debounced key level into single-cycle press / release / short / long /
// auto-repeat event pulses, plus a registered held flag.
module key_event #(
    parameter int CNT_W      = 27,
    parameter int LONG_CNT   = 100000000,
    parameter int REPEAT_CNT = 20000000
) (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic press,
    // release/repeat are reserved words, hence the _pulse suffix on these two
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);
    localparam bit               REPEAT_EN   = (REPEAT_CNT != 0);

    state_t           state;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;

            case (state)
                IDLE: begin
                    if (level) begin
                        press <= 1'b1;
                        held  <= 1'b1;
                        count <= '0;
                        state <= PRESSED;
                    end
                end

                // a release seen on this edge wins over the long-press terminal count
                PRESSED: begin
                    if (!level) begin
                        release_pulse <= 1'b1;
                        short_press   <= 1'b1;
                        held          <= 1'b0;
                        state         <= IDLE;
                    end else if (count == LONG_LAST) begin
                        long_press <= 1'b1;
                        count      <= '0;
                        state      <= LONG;
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                LONG: begin
                    if (!level) begin
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                        state         <= IDLE;
                    end else if (REPEAT_EN) begin
                        if (count == REPEAT_LAST) begin
                            repeat_pulse <= 1'b1;
                            count        <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end

                default: begin
                    held  <= 1'b0;
                    count <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event: a per-cycle vector table plus hand-written
// sequences for reset-while-held and back-to-back presses.
module tb_key_event;

    localparam int CNT_W      = 4;
    localparam int LONG_CNT   = 8;
    localparam int REPEAT_CNT = 4;

    // expected output word: {press, release, short, long, repeat, held}
    localparam logic [5:0] NONE      = 6'b000000;
    localparam logic [5:0] HELD      = 6'b000001;
    localparam logic [5:0] PRESS     = 6'b100001;
    localparam logic [5:0] REL_SHORT = 6'b011000;
    localparam logic [5:0] REL       = 6'b010000;
    localparam logic [5:0] LONG_P    = 6'b000101;
    localparam logic [5:0] REP       = 6'b000011;

    logic clock = 1'b0;
    logic reset;
    logic level;
    logic press, release_pulse, short_press, long_press, repeat_pulse, held;

    key_event #(
        .CNT_W     (CNT_W),
        .LONG_CNT  (LONG_CNT),
        .REPEAT_CNT(REPEAT_CNT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .held         (held)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       lvl;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic r, input logic l, input logic [5:0] e, input string n);
        vec_t v;
        v.rst  = r;
        v.lvl  = l;
        v.exp  = e;
        v.name = n;
        vecs.push_back(v);
    endtask

    task automatic add_n(input int n, input logic r, input logic l, input logic [5:0] e,
                         input string name);
        for (int i = 0; i < n; i++) add(r, l, e, name);
    endtask

    task automatic step(input logic r, input logic l);
        reset = r;
        level = l;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = {press, release_pulse, short_press, long_press, repeat_pulse, held};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b (press,rel,short,long,rep,held)",
                     name, $time, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        level = 1'b0;

        // reset with key held, then the first clean edge is a fresh press
        add_n(3, 1'b1, 1'b1, NONE, "reset_hold");
        add(0, 1, PRESS, "press_after_reset");
        // short press: held for e1..e4, released at e5
        add_n(4, 1'b0, 1'b1, HELD, "short_held");
        add(0, 0, REL_SHORT, "short_release");
        add(0, 0, NONE, "short_idle");

        // long boundary: release sampled at e8 still counts as short
        add(0, 1, PRESS, "bound_press");
        add_n(7, 1'b0, 1'b1, HELD, "bound_held");
        add(0, 0, REL_SHORT, "bound_short_at_e8");
        add(0, 0, NONE, "bound_idle");

        // held through e8: long_press exactly 8 cycles after press
        add(0, 1, PRESS, "long_press_edge");
        add_n(7, 1'b0, 1'b1, HELD, "long_held");
        add(0, 1, LONG_P, "long_pulse");
        add(0, 0, REL, "long_release");
        add(0, 0, NONE, "long_idle");

        // auto-repeat at +12, +16, +20, released at e22
        add(0, 1, PRESS, "rep_press");
        add_n(7, 1'b0, 1'b1, HELD, "rep_held_a");
        add(0, 1, LONG_P, "rep_long");
        add_n(3, 1'b0, 1'b1, HELD, "rep_held_b");
        add(0, 1, REP, "rep_pulse_12");
        add_n(3, 1'b0, 1'b1, HELD, "rep_held_c");
        add(0, 1, REP, "rep_pulse_16");
        add_n(3, 1'b0, 1'b1, HELD, "rep_held_d");
        add(0, 1, REP, "rep_pulse_20");
        add(0, 1, HELD, "rep_held_e");
        add(0, 0, REL, "rep_release");
        add(0, 0, NONE, "rep_idle");

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].lvl);
            check(vecs[i].name, vecs[i].exp);
        end

        // reset 10 cycles into a hold: no release, then a fresh press
        step(0, 1);
        check("mid_press", PRESS);
        for (int i = 1; i <= 7; i++) begin
            step(0, 1);
            check("mid_held", HELD);
        end
        step(0, 1);
        check("mid_long", LONG_P);
        step(0, 1);
        check("mid_held_e9", HELD);
        step(0, 1);
        check("mid_held_e10", HELD);
        step(1, 1);
        check("mid_reset_no_release", NONE);
        step(1, 1);
        check("mid_reset_hold", NONE);
        step(0, 1);
        check("mid_repress", PRESS);
        step(0, 0);
        check("mid_rerelease", REL_SHORT);
        step(0, 0);
        check("mid_idle", NONE);

        // back-to-back 1,0,1,0 on consecutive edges
        step(0, 1);
        check("b2b_press1", PRESS);
        step(0, 0);
        check("b2b_release1", REL_SHORT);
        step(0, 1);
        check("b2b_press2", PRESS);
        step(0, 0);
        check("b2b_release2", REL_SHORT);
        step(0, 0);
        check("b2b_idle", NONE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
